// File: rtl/vslc_servo_bank.sv
// Bank of NCH servo PWM channels sharing one prescaled frame counter.
// Writes land in shadow registers; active registers reload at the frame wrap.
module vslc_servo_bank #(
  parameter int NCH          = 4,
  parameter int CLK_DIV      = 0,
  parameter int PERIOD_TICKS = 20000,
  parameter int MIN_TICKS    = 1000,
  parameter int POS_W        = 8,
  parameter int SCALE        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_ch,
  input  logic [POS_W-1:0] wr_pos,
  input  logic             wr_ena,
  output logic [NCH-1:0]   servo_out,
  output logic             frame_start,
  output logic             tick
);

  localparam int FCW = $clog2(PERIOD_TICKS);
  localparam int PSW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(CLK_DIV);
  localparam logic [FCW-1:0] FC_LAST = FCW'(PERIOD_TICKS - 1);

  if (MIN_TICKS + ((1 << POS_W) - 1) * SCALE >= PERIOD_TICKS) begin : g_bad_range
    $error("vslc_servo_bank: widest pulse does not fit in the frame");
  end
  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("vslc_servo_bank: NCH must be 1..8");
  end

  logic [PSW-1:0]   psc_q, psc_d;
  logic [FCW-1:0]   fc_q, fc_d;
  logic             tick_q;
  logic             ps_wrap, fc_wrap;
  logic [NCH-1:0]   sh_ena_q, ac_ena_q;
  logic [POS_W-1:0] sh_pos_q [NCH];
  logic [POS_W-1:0] ac_pos_q [NCH];
  logic [FCW-1:0]   width    [NCH];
  logic [NCH-1:0]   servo_q, servo_d;

  assign ps_wrap = (psc_q == PS_LAST);
  assign fc_wrap = ps_wrap && (fc_q == FC_LAST);
  assign psc_d   = ps_wrap ? '0 : psc_q + 1'b1;
  assign fc_d    = fc_wrap ? '0 : (ps_wrap ? fc_q + 1'b1 : fc_q);

  always_comb begin
    servo_d = '0;
    for (int i = 0; i < NCH; i++) begin
      width[i]   = FCW'(MIN_TICKS) + FCW'(ac_pos_q[i]) * FCW'(SCALE);
      servo_d[i] = ac_ena_q[i] && (fc_q < width[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q    <= '0;
      fc_q     <= '0;
      tick_q   <= 1'b0;
      servo_q  <= '0;
      sh_ena_q <= '0;
      ac_ena_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        sh_pos_q[i] <= '0;
        ac_pos_q[i] <= '0;
      end
    end else begin
      psc_q   <= psc_d;
      fc_q    <= fc_d;
      tick_q  <= ps_wrap;
      servo_q <= servo_d;
      // active takes the pre-write shadow when a write hits the wrap edge
      for (int i = 0; i < NCH; i++) begin
        if (fc_wrap) begin
          ac_ena_q[i] <= sh_ena_q[i];
          ac_pos_q[i] <= sh_pos_q[i];
        end
        if (wr_en && (wr_ch == 3'(i))) begin
          sh_ena_q[i] <= wr_ena;
          sh_pos_q[i] <= wr_pos;
        end
      end
    end
  end

  assign servo_out   = servo_q;
  assign tick        = tick_q;
  assign frame_start = fc_wrap;

endmodule
